// File: rtl/hazard_ctrl_mc_if.sv
// Datapath <-> hazard unit bundle: register indices, write enables, branch/MDU
// handshake going in; stall/flush/forward controls and perf counters coming back.
interface hazard_ctrl_mc_if #(
   parameter int REG_ADDR_W = 5,
   parameter int PERF_W     = 32
);
   logic [REG_ADDR_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic                  RegWriteM, RegWriteW;
   logic                  ResultSrcE0, PCSrcE, MduStartE, MduDoneE;
   logic                  StallF, StallD, StallE;
   logic                  FlushD, FlushE, FlushM;
   logic [1:0]            ForwardAE, ForwardBE;
   logic [PERF_W-1:0]     LoadStallCnt, MduStallCnt, FlushCnt;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MduStartE, MduDoneE,
      input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
      input  ForwardAE, ForwardBE, LoadStallCnt, MduStallCnt, FlushCnt
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MduStartE, MduDoneE,
      output StallF, StallD, StallE, FlushD, FlushE, FlushM,
      output ForwardAE, ForwardBE, LoadStallCnt, MduStallCnt, FlushCnt
   );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// Clocked hazard unit: forwarding, multi-bubble load-use stall, MDU busy stall, branch flush.
// Define HAZARD_PERF_EN to build the saturating performance counters.
module hazard_ctrl_mc #(
   parameter int REG_ADDR_W   = 5,
   parameter int LOAD_BUBBLES = 1,
   parameter int PERF_W       = 32
) (
   input logic             clk,
   input logic             reset,
   hazard_ctrl_mc_if.slave hz
);

   typedef enum logic [1:0] {IDLE, LOAD_WAIT, MDU_BUSY} state_t;

   state_t     state, state_next;
   logic [1:0] bcnt, bcnt_next;
   logic       lw_hit, load_stall;
   logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
   logic [1:0] fwd_a, fwd_b;

   function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs, rdm, rdw,
                                          input logic wem, wew);
      if (rs != '0 && rs == rdm && wem)      return 2'b10;
      else if (rs != '0 && rs == rdw && wew) return 2'b01;
      else                                   return 2'b00;
   endfunction

   assign fwd_a  = reset ? 2'b00 : fwd_sel(hz.Rs1E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);
   assign fwd_b  = reset ? 2'b00 : fwd_sel(hz.Rs2E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);
   assign lw_hit = hz.ResultSrcE0 && (hz.RdE != '0) && (hz.Rs1D == hz.RdE || hz.Rs2D == hz.RdE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         bcnt  <= 2'd0;
      end else begin
         state <= state_next;
         bcnt  <= bcnt_next;
      end
   end

   always_comb begin
      state_next = state;
      bcnt_next  = bcnt;
      load_stall = 1'b0;
      stall_f    = 1'b0;
      stall_d    = 1'b0;
      stall_e    = 1'b0;
      flush_d    = 1'b0;
      flush_e    = 1'b0;
      flush_m    = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: begin
               // A taken branch squashes the younger instructions, so any hazard they raise is moot.
               if (hz.PCSrcE) begin
                  flush_d = 1'b1;
                  flush_e = 1'b1;
               end else if (lw_hit) begin
                  stall_f    = 1'b1;
                  stall_d    = 1'b1;
                  flush_e    = 1'b1;
                  load_stall = 1'b1;
                  if (LOAD_BUBBLES > 1) begin
                     state_next = LOAD_WAIT;
                     bcnt_next  = 2'(LOAD_BUBBLES - 1);
                  end
               end else if (hz.MduStartE && !hz.MduDoneE) begin
                  stall_f    = 1'b1;
                  stall_d    = 1'b1;
                  stall_e    = 1'b1;
                  flush_m    = 1'b1;
                  state_next = MDU_BUSY;
               end
            end
            LOAD_WAIT: begin
               if (hz.PCSrcE) begin
                  flush_d    = 1'b1;
                  flush_e    = 1'b1;
                  state_next = IDLE;
                  bcnt_next  = 2'd0;
               end else begin
                  stall_f    = 1'b1;
                  stall_d    = 1'b1;
                  flush_e    = 1'b1;
                  load_stall = 1'b1;
                  bcnt_next  = bcnt - 2'd1;
                  if (bcnt == 2'd1) state_next = IDLE;
               end
            end
            MDU_BUSY: begin
               if (!hz.MduDoneE) begin
                  stall_f = 1'b1;
                  stall_d = 1'b1;
                  stall_e = 1'b1;
                  flush_m = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign hz.StallF    = stall_f;
   assign hz.StallD    = stall_d;
   assign hz.StallE    = stall_e;
   assign hz.FlushD    = flush_d;
   assign hz.FlushE    = flush_e;
   assign hz.FlushM    = flush_m;
   assign hz.ForwardAE = fwd_a;
   assign hz.ForwardBE = fwd_b;

`ifdef HAZARD_PERF_EN
   logic [PERF_W-1:0] load_cnt, mdu_cnt, flush_cnt;

   // Counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_cnt  <= '0;
         mdu_cnt   <= '0;
         flush_cnt <= '0;
      end else begin
         if (load_stall && load_cnt != '1) load_cnt  <= load_cnt + 1'b1;
         if (stall_e && mdu_cnt != '1)     mdu_cnt   <= mdu_cnt + 1'b1;
         if (flush_d && flush_cnt != '1)   flush_cnt <= flush_cnt + 1'b1;
      end
   end

   assign hz.LoadStallCnt = load_cnt;
   assign hz.MduStallCnt  = mdu_cnt;
   assign hz.FlushCnt     = flush_cnt;
`else
   assign hz.LoadStallCnt = {PERF_W{1'b0}};
   assign hz.MduStallCnt  = {PERF_W{1'b0}};
   assign hz.FlushCnt     = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench for hazard_ctrl_mc with LOAD_BUBBLES=2; expected control words are
// queued as each cycle is driven and compared at the following falling edge.
module tb_hazard_ctrl_mc;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   hazard_ctrl_mc_if #(.REG_ADDR_W(5), .PERF_W(32)) hz ();

   hazard_ctrl_mc #(.REG_ADDR_W(5), .LOAD_BUBBLES(2), .PERF_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   // Control word layout: StallF StallD StallE FlushD FlushE FlushM ForwardAE ForwardBE
   localparam logic [9:0] W_NONE = 10'b000_000_00_00;
   localparam logic [9:0] W_LOAD = 10'b110_010_00_00;
   localparam logic [9:0] W_MDU  = 10'b111_001_00_00;
   localparam logic [9:0] W_BR   = 10'b000_110_00_00;

   typedef struct {
      string      tag;
      logic [9:0] word;
   } exp_t;

   exp_t       expQ[$];
   int         checks = 0;
   int         errors = 0;
   logic [9:0] obs;

   assign obs = {hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushM,
                 hz.ForwardAE, hz.ForwardBE};

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic clearInputs();
      hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
      hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
      hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.ResultSrcE0 = 1'b0;
      hz.PCSrcE = 1'b0; hz.MduStartE = 1'b0; hz.MduDoneE = 1'b0;
   endtask

   task automatic applyStimulus(input string tag, input logic [9:0] word);
      exp_t e;
      e.tag  = tag;
      e.word = word;
      expQ.push_back(e);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
      clearInputs();
   endtask

   function automatic logic [63:0] perfExp(input int v);
`ifdef HAZARD_PERF_EN
      return 64'(v);
`else
      return 64'(v * 0);
`endif
   endfunction

   task automatic checkCounters(input string tag, input int ld, input int md, input int fl);
      @(negedge clk);
      #1;
      checkOutput({tag, "_load_cnt"},  64'(hz.LoadStallCnt), perfExp(ld));
      checkOutput({tag, "_mdu_cnt"},   64'(hz.MduStallCnt),  perfExp(md));
      checkOutput({tag, "_flush_cnt"}, 64'(hz.FlushCnt),     perfExp(fl));
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput(e.tag, 64'(obs), 64'(e.word));
      end
   end

   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;
      clearInputs();
      hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
      hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1'b1; hz.PCSrcE = 1'b1;
      applyStimulus("reset_outputs", W_NONE);
      checkCounters("reset", 0, 0, 0);

      @(posedge clk); #1;
      reset = 1'b0;
      clearInputs();
      hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1'b1; hz.RdW = 5'd5; hz.RegWriteW = 1'b1;
      applyStimulus("fwd_a_from_m", 10'b000_000_10_00);

      nextCycle();
      hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.RdW = 5'd5; hz.RegWriteW = 1'b1;
      applyStimulus("fwd_a_from_w", 10'b000_000_01_00);

      nextCycle();
      hz.RdM = 5'd0; hz.RegWriteM = 1'b1; hz.RdW = 5'd0; hz.RegWriteW = 1'b1;
      applyStimulus("fwd_a_x0", W_NONE);

      nextCycle();
      hz.Rs2E = 5'd9; hz.RdW = 5'd9; hz.RegWriteW = 1'b1; hz.RdM = 5'd3; hz.RegWriteM = 1'b1;
      applyStimulus("fwd_b_from_w", 10'b000_000_00_01);

      nextCycle();
      hz.Rs1E = 5'd4; hz.Rs2E = 5'd4; hz.RdM = 5'd4; hz.RegWriteM = 1'b1;
      applyStimulus("fwd_ab_from_m", 10'b000_000_10_10);

      nextCycle();
      hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
      applyStimulus("load_bubble1", W_LOAD);
      nextCycle();
      applyStimulus("load_bubble2", W_LOAD);
      nextCycle();
      applyStimulus("load_release", W_NONE);
      checkCounters("after_load", 2, 0, 0);

      nextCycle();
      hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd0; hz.Rs1D = 5'd0;
      applyStimulus("load_x0_no_stall", W_NONE);

      nextCycle();
      hz.MduStartE = 1'b1;
      applyStimulus("mdu_t0", W_MDU);
      for (int i = 1; i < 4; i++) begin
         nextCycle();
         applyStimulus($sformatf("mdu_t%0d", i), W_MDU);
      end
      nextCycle();
      hz.MduDoneE = 1'b1;
      applyStimulus("mdu_done", W_NONE);
      nextCycle();
      applyStimulus("mdu_idle", W_NONE);
      checkCounters("after_mdu", 2, 4, 0);

      nextCycle();
      hz.MduStartE = 1'b1; hz.MduDoneE = 1'b1;
      applyStimulus("mdu_single_cycle", W_NONE);
      nextCycle();
      applyStimulus("mdu_single_after", W_NONE);

      nextCycle();
      hz.PCSrcE = 1'b1; hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd6; hz.Rs1D = 5'd6;
      applyStimulus("branch_over_load", W_BR);
      nextCycle();
      applyStimulus("branch_after", W_NONE);
      checkCounters("after_branch", 2, 4, 1);

      nextCycle();
      hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd8; hz.Rs1D = 5'd8;
      applyStimulus("load_before_branch", W_LOAD);
      nextCycle();
      hz.PCSrcE = 1'b1;
      applyStimulus("branch_in_load_wait", W_BR);
      nextCycle();
      applyStimulus("branch_wait_exit", W_NONE);
      checkCounters("after_wait_branch", 3, 4, 2);

      nextCycle();
      hz.MduStartE = 1'b1;
      applyStimulus("mdu_pre_reset0", W_MDU);
      nextCycle();
      applyStimulus("mdu_pre_reset1", W_MDU);
      nextCycle();
      reset = 1'b1;
      hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1'b1;
      applyStimulus("reset_in_mdu", W_NONE);
      checkCounters("reset_in_mdu", 0, 0, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      clearInputs();
      applyStimulus("post_reset_no_stall", W_NONE);
      nextCycle();
      applyStimulus("post_reset_idle", W_NONE);

      @(negedge clk);
      #1;
      if (expQ.size() != 0) checkOutput("scoreboard_drain", 64'(expQ.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_mc.md
# hazard_ctrl_mc

Parametrised, clocked successor of the pipeline hazard unit for the 5-stage RISC-V core. It sits beside the datapath and produces the E-stage forwarding selects and the F/D/E/M stall and flush controls. It extends the combinational load-use and branch logic with three additions:
- a configurable multi-bubble load-use stall;
- a handshake-driven stall for multi-cycle MUL/DIV operations in E;
- correct priority between branch flush and stalls.

## Interface
Parameters:
- REG_ADDR_W, 5, register-index width
- LOAD_BUBBLES, 1, bubbles inserted per load-use hazard (legal 1..3)
- PERF_W, 32, width of performance counters

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high
- Rs1D, Rs2D  in  REG_ADDR_W  D-stage source registers
- Rs1E, Rs2E, RdE  in  REG_ADDR_W  E-stage sources and destination
- RdM, RdW  in  REG_ADDR_W  M/W destinations
- RegWriteM, RegWriteW  in  1  M/W write enables
- ResultSrcE0  in  1  E instruction is a load
- PCSrcE  in  1  taken branch/jump resolved in E
- MduStartE  in  1  E instruction is a multi-cycle MDU op (first E cycle)
- MduDoneE  in  1  MDU result valid this cycle
- StallF, StallD, StallE  out  1  hold stage register
- FlushD, FlushE, FlushM  out  1  clear stage register (bubble)
- ForwardAE, ForwardBE  out  2  00 regfile, 01 from W, 10 from M
- LoadStallCnt, MduStallCnt, FlushCnt  out  PERF_W  performance counters

## Operation
- Forwarding, combinational:
  - ForwardAE = 10 if Rs1E==RdM && RegWriteM && Rs1E!=0.
  - Otherwise 01 if Rs1E==RdW && RegWriteW && Rs1E!=0.
  - Otherwise 00. M has priority over W.
  - ForwardBE follows the same rules with Rs2E.
- lwHit = ResultSrcE0 && RdE!=0 && (Rs1D==RdE || Rs2D==RdE). Unlike the previous unit, a load to x0 never stalls.
- FSM states: IDLE, LOAD_WAIT, MDU_BUSY. A 2-bit bubble counter `bcnt`.
- IDLE:
  - PCSrcE: FlushD=1, FlushE=1, no stalls; lwHit is suppressed. Branch has highest priority.
  - Else lwHit: StallF=StallD=FlushE=1. If LOAD_BUBBLES>1, go to LOAD_WAIT with bcnt=LOAD_BUBBLES-1.
  - Else MduStartE && !MduDoneE: StallF=StallD=StallE=FlushM=1; go to MDU_BUSY.
  - MduStartE && MduDoneE (single-cycle result): no stall, remain IDLE.
- LOAD_WAIT:
  - StallF=StallD=FlushE=1; bcnt decrements.
  - When bcnt==1 at a clock edge, return to IDLE.
  - PCSrcE asserted here: FlushD=FlushE=1, stalls deasserted, go to IDLE.
- MDU_BUSY:
  - While !MduDoneE: StallF=StallD=StallE=FlushM=1.
  - Cycle with MduDoneE=1: no stall; return to IDLE.
- All unlisted outputs are 0.
- Perf counters, saturating at all-ones:
  - LoadStallCnt +1 per cycle with a load-use stall.
  - MduStallCnt +1 per cycle with StallE=1.
  - FlushCnt +1 per cycle with PCSrcE-induced FlushD.

## Timing
- Forward/stall/flush outputs are combinational from inputs and registered state. Zero latency.
- While reset is high:
  - state=IDLE, bcnt=0, counters=0.
  - All stall/flush outputs are 0 and ForwardAE/BE=00, regardless of inputs.
- Load-use detected at cycle t: stalls asserted for cycles t..t+LOAD_BUBBLES-1 exactly, then released.
- MDU start at t, done at t+k: StallE=1 for cycles t..t+k-1 (k cycles); 0 at t+k.
- Reset asserted mid-LOAD_WAIT or MDU_BUSY: outputs drop to 0 immediately (asynchronous). IDLE on release.

## Configuration
- HAZARD_PERF_EN defined: the three counters are implemented as above.
- HAZARD_PERF_EN undefined: counter registers are not built. The ports remain and are tied to 0.

## Test plan
- Forwarding: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. Same with RegWriteM=0 -> 01. Rs1E=0 -> 00.
- LOAD_BUBBLES=2: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF/StallD/FlushE high for exactly 2 cycles. LoadStallCnt=2. RdE=0 -> no stall.
- MDU: MduStartE=1 at t, MduDoneE=1 at t+4 -> StallE and FlushM high for cycles t..t+3. MduStallCnt=4. Start and done in the same cycle -> no stall.
- Branch priority: PCSrcE=1 with lwHit true -> FlushD=FlushE=1, StallF=StallD=0. FlushCnt increments by 1.
- Reset asserted during MDU_BUSY -> all outputs 0 immediately. After release, MduDoneE=0 produces no stall.
- Build without HAZARD_PERF_EN -> all three counters read 0 after the scenarios above.
